// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: address widths, hold/jump enable levels,
// controller state encodings and the bundled per-stage control word.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned INST_ADDR_W = 32;

    localparam logic HOLD_ENABLE = 1'b1;
    localparam logic JUMP_ENABLE = 1'b1;

    localparam logic [1:0] PCTRL_RUN = 2'd0;
    localparam logic [1:0] PCTRL_DIV = 2'd1;
    localparam logic [1:0] PCTRL_MEM = 2'd2;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic hold_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic pc_jump;
    } ctrl_t;

    function automatic ctrl_t ctrl_mem_stall();
        ctrl_t c;
        c             = '0;
        c.hold_pc     = HOLD_ENABLE;
        c.hold_if_id  = HOLD_ENABLE;
        c.hold_id_ex  = HOLD_ENABLE;
        c.hold_ex_mem = HOLD_ENABLE;
        return c;
    endfunction

    function automatic ctrl_t ctrl_div_busy();
        ctrl_t c;
        c              = '0;
        c.hold_pc      = HOLD_ENABLE;
        c.hold_if_id   = HOLD_ENABLE;
        c.hold_id_ex   = HOLD_ENABLE;
        c.flush_ex_mem = JUMP_ENABLE;
        return c;
    endfunction

    function automatic ctrl_t ctrl_jump();
        ctrl_t c;
        c             = '0;
        c.flush_if_id = JUMP_ENABLE;
        c.flush_id_ex = JUMP_ENABLE;
        c.pc_jump     = JUMP_ENABLE;
        return c;
    endfunction

    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c             = '0;
        c.hold_pc     = HOLD_ENABLE;
        c.hold_if_id  = HOLD_ENABLE;
        c.flush_id_ex = JUMP_ENABLE;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a
// load currently in EX. Purely combinational.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_reg1_r_addr_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_r_addr_i,
    input  logic                  id_reg1_r_ena_i,
    input  logic                  id_reg2_r_ena_i,
    input  logic                  ex_mem_r_ena_i,
    input  logic [REG_ADDR_W-1:0] ex_reg_w_addr_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_valid;

    always_comb begin
        // x0 is hard-wired zero, so a load targeting it never creates a dependency
        rd_valid   = ex_mem_r_ena_i && (ex_reg_w_addr_i != '0);
        rs1_hit    = id_reg1_r_ena_i && (id_reg1_r_addr_i == ex_reg_w_addr_i);
        rs2_hit    = id_reg2_r_ena_i && (id_reg2_r_addr_i == ex_reg_w_addr_i);
        load_use_o = rd_valid && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/flow controller: per-stage holds and flushes from memory waits,
// multi-cycle divides, EX jumps and load-use hazards, plus a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = 8,
    parameter int unsigned MEM_TIMEOUT = 16
)
(
    input  logic                   clk_100MHz,
    input  logic                   arst_n,
    input  logic [REG_ADDR_W-1:0]  id_reg1_r_addr_i,
    input  logic [REG_ADDR_W-1:0]  id_reg2_r_addr_i,
    input  logic                   id_reg1_r_ena_i,
    input  logic                   id_reg2_r_ena_i,
    input  logic                   ex_mem_r_ena_i,
    input  logic [REG_ADDR_W-1:0]  ex_reg_w_addr_i,
    input  logic                   ex_jump_ena_i,
    input  logic [INST_ADDR_W-1:0] ex_jump_addr_i,
    input  logic                   ex_div_start_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ack_i,
    output logic                   hold_pc_o,
    output logic                   hold_if_id_o,
    output logic                   hold_id_ex_o,
    output logic                   hold_ex_mem_o,
    output logic                   flush_if_id_o,
    output logic                   flush_id_ex_o,
    output logic                   flush_ex_mem_o,
    output logic                   pc_jump_ena_o,
    output logic [INST_ADDR_W-1:0] pc_jump_addr_o,
    output logic                   div_done_o,
    output logic                   bus_err_o,
    output logic [31:0]            stall_cnt_o
);

    localparam int unsigned DIV_W = ($clog2(DIV_CYCLES) > 0) ? $clog2(DIV_CYCLES) : 1;
    localparam int unsigned MEM_W = ($clog2(MEM_TIMEOUT) > 0) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_CNT_INIT = DIV_W'(DIV_CYCLES - 2);
    localparam logic [MEM_W-1:0] MEM_CNT_INIT = MEM_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [MEM_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             div_frozen_q, div_frozen_d;
    logic [31:0]      stall_cnt_q;

    ctrl_t                  ctrl;
    logic [INST_ADDR_W-1:0] jump_addr;
    logic                   div_done;
    logic                   bus_err;
    logic                   load_use;
    logic                   in_mem;
    logic                   mem_stall;
    logic                   mem_timeout;
    logic                   div_active;
    logic                   div_busy;

    hazard_detect u_hazard_detect (
        .id_reg1_r_addr_i (id_reg1_r_addr_i),
        .id_reg2_r_addr_i (id_reg2_r_addr_i),
        .id_reg1_r_ena_i  (id_reg1_r_ena_i),
        .id_reg2_r_ena_i  (id_reg2_r_ena_i),
        .ex_mem_r_ena_i   (ex_mem_r_ena_i),
        .ex_reg_w_addr_i  (ex_reg_w_addr_i),
        .load_use_o       (load_use)
    );

    always_comb begin
        in_mem      = (state_q == PCTRL_MEM);
        mem_stall   = dmem_req_i && !dmem_ack_i && (!in_mem || (wait_cnt_q != '0));
        mem_timeout = in_mem && dmem_req_i && !dmem_ack_i && (wait_cnt_q == '0);
        // A divide interrupted by a memory wait resumes in the cycle the wait ends
        div_active  = (state_q == PCTRL_DIV) || (in_mem && div_frozen_q);
    end

    always_comb begin
        ctrl         = '0;
        jump_addr    = '0;
        div_done     = 1'b0;
        bus_err      = 1'b0;
        div_busy     = 1'b0;
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        div_frozen_d = div_frozen_q;

        if (mem_stall) begin
            ctrl    = ctrl_mem_stall();
            state_d = PCTRL_MEM;
            if (in_mem) begin
                wait_cnt_d = wait_cnt_q - MEM_W'(1);
            end else begin
                wait_cnt_d   = MEM_CNT_INIT;
                div_frozen_d = (state_q == PCTRL_DIV);
            end
        end else begin
            state_d      = PCTRL_RUN;
            div_frozen_d = 1'b0;

            if (mem_timeout) begin
                bus_err = 1'b1;
            end else if (div_active) begin
                if (div_cnt_q != '0) begin
                    ctrl      = ctrl_div_busy();
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                    state_d   = PCTRL_DIV;
                    div_busy  = 1'b1;
                end else begin
                    div_done = 1'b1;
                end
            end else if (ex_div_start_i) begin
                ctrl      = ctrl_div_busy();
                div_cnt_d = DIV_CNT_INIT;
                state_d   = PCTRL_DIV;
                div_busy  = 1'b1;
            end

            // Jump squashes the ID instruction, so it also masks its load-use hazard
            if (!div_busy) begin
                if (ex_jump_ena_i) begin
                    ctrl      = ctrl_jump();
                    jump_addr = ex_jump_addr_i;
                end else if (load_use) begin
                    ctrl = ctrl_load_use();
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= PCTRL_RUN;
            div_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            div_frozen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            div_frozen_q <= div_frozen_d;
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
        end else if (hold_pc_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Controls are Mealy, so they are masked directly while reset is asserted
    always_comb begin
        hold_pc_o      = arst_n && ctrl.hold_pc;
        hold_if_id_o   = arst_n && ctrl.hold_if_id;
        hold_id_ex_o   = arst_n && ctrl.hold_id_ex;
        hold_ex_mem_o  = arst_n && ctrl.hold_ex_mem;
        flush_if_id_o  = arst_n && ctrl.flush_if_id;
        flush_id_ex_o  = arst_n && ctrl.flush_id_ex;
        flush_ex_mem_o = arst_n && ctrl.flush_ex_mem;
        pc_jump_ena_o  = arst_n && ctrl.pc_jump;
        pc_jump_addr_o = arst_n ? jump_addr : '0;
        div_done_o     = arst_n && div_done;
        bus_err_o      = arst_n && bus_err;
        stall_cnt_o    = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control words are queued as each step is
// driven and popped when the outputs are sampled mid-cycle.
module tb_pipe_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        arst_n;
    logic [4:0]  id_reg1_r_addr_i, id_reg2_r_addr_i;
    logic        id_reg1_r_ena_i, id_reg2_r_ena_i;
    logic        ex_mem_r_ena_i;
    logic [4:0]  ex_reg_w_addr_i;
    logic        ex_jump_ena_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_div_start_i;
    logic        dmem_req_i, dmem_ack_i;
    logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o;
    logic        pc_jump_ena_o;
    logic [31:0] pc_jump_addr_o;
    logic        div_done_o, bus_err_o;
    logic [31:0] stall_cnt_o;

    typedef struct packed {
        logic [3:0]  hold;   // pc, if_id, id_ex, ex_mem
        logic [2:0]  flush;  // if_id, id_ex, ex_mem
        logic        jmp;
        logic [31:0] addr;
        logic        done;
        logic        err;
    } obs_t;

    localparam obs_t E_NONE = '0;
    localparam obs_t E_LU   = '{hold: 4'b1100, flush: 3'b010, jmp: 1'b0, addr: 32'h0, done: 1'b0, err: 1'b0};
    localparam obs_t E_DIV  = '{hold: 4'b1110, flush: 3'b001, jmp: 1'b0, addr: 32'h0, done: 1'b0, err: 1'b0};
    localparam obs_t E_MEM  = '{hold: 4'b1111, flush: 3'b000, jmp: 1'b0, addr: 32'h0, done: 1'b0, err: 1'b0};
    localparam obs_t E_DONE = '{hold: 4'b0000, flush: 3'b000, jmp: 1'b0, addr: 32'h0, done: 1'b1, err: 1'b0};
    localparam obs_t E_ERR  = '{hold: 4'b0000, flush: 3'b000, jmp: 1'b0, addr: 32'h0, done: 1'b0, err: 1'b1};

    obs_t        exp_q[$];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_stall = '0;

    pipe_ctrl #(.DIV_CYCLES(8), .MEM_TIMEOUT(4)) dut (
        .clk_100MHz       (clk_100MHz),
        .arst_n           (arst_n),
        .id_reg1_r_addr_i (id_reg1_r_addr_i),
        .id_reg2_r_addr_i (id_reg2_r_addr_i),
        .id_reg1_r_ena_i  (id_reg1_r_ena_i),
        .id_reg2_r_ena_i  (id_reg2_r_ena_i),
        .ex_mem_r_ena_i   (ex_mem_r_ena_i),
        .ex_reg_w_addr_i  (ex_reg_w_addr_i),
        .ex_jump_ena_i    (ex_jump_ena_i),
        .ex_jump_addr_i   (ex_jump_addr_i),
        .ex_div_start_i   (ex_div_start_i),
        .dmem_req_i       (dmem_req_i),
        .dmem_ack_i       (dmem_ack_i),
        .hold_pc_o        (hold_pc_o),
        .hold_if_id_o     (hold_if_id_o),
        .hold_id_ex_o     (hold_id_ex_o),
        .hold_ex_mem_o    (hold_ex_mem_o),
        .flush_if_id_o    (flush_if_id_o),
        .flush_id_ex_o    (flush_id_ex_o),
        .flush_ex_mem_o   (flush_ex_mem_o),
        .pc_jump_ena_o    (pc_jump_ena_o),
        .pc_jump_addr_o   (pc_jump_addr_o),
        .div_done_o       (div_done_o),
        .bus_err_o        (bus_err_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic obs_t e_jump(input logic [31:0] a);
        obs_t r;
        r       = '0;
        r.flush = 3'b110;
        r.jmp   = 1'b1;
        r.addr  = a;
        return r;
    endfunction

    task automatic idle();
        id_reg1_r_addr_i = '0;
        id_reg2_r_addr_i = '0;
        id_reg1_r_ena_i  = 1'b0;
        id_reg2_r_ena_i  = 1'b0;
        ex_mem_r_ena_i   = 1'b0;
        ex_reg_w_addr_i  = '0;
        ex_jump_ena_i    = 1'b0;
        ex_jump_addr_i   = '0;
        ex_div_start_i   = 1'b0;
        dmem_req_i       = 1'b0;
        dmem_ack_i       = 1'b0;
    endtask

    // Inputs are already driven; queue the expectation, sample 1 ns later, then
    // advance to the next falling edge (one rising edge in between).
    task automatic step(input obs_t e, input string tag);
        obs_t act, want;
        exp_q.push_back(e);
        #1;
        act = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
               flush_if_id_o, flush_id_ex_o, flush_ex_mem_o,
               pc_jump_ena_o, pc_jump_addr_o, div_done_o, bus_err_o};
        want = exp_q.pop_front();
        n_assert++;
        assert (act === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, want);
        end
        if (want.hold[3] && arst_n && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        @(negedge clk_100MHz);
    endtask

    task automatic chk_cnt(input string tag);
        #1;
        n_assert++;
        assert (stall_cnt_o === exp_stall) else begin
            n_fail++;
            $error("FAIL %s: observed stall_cnt %h expected %h", tag, stall_cnt_o, exp_stall);
        end
    endtask

    initial begin
        // Reset asserted with active-looking inputs: every control must stay low
        arst_n = 1'b0;
        idle();
        ex_div_start_i = 1'b1;
        dmem_req_i     = 1'b1;
        ex_jump_ena_i  = 1'b1;
        ex_jump_addr_i = 32'h0000_0040;
        step(E_NONE, "reset_gating");
        chk_cnt("reset_cnt");
        idle();
        arst_n = 1'b1;
        step(E_NONE, "idle_after_reset");

        // Load-use on rs1, then normal flow, then on rs2
        ex_mem_r_ena_i = 1'b1; ex_reg_w_addr_i = 5'd5;
        id_reg1_r_addr_i = 5'd5; id_reg1_r_ena_i = 1'b1;
        step(E_LU, "load_use_rs1");
        idle();
        step(E_NONE, "after_load_use");
        ex_mem_r_ena_i = 1'b1; ex_reg_w_addr_i = 5'd5;
        id_reg1_r_addr_i = 5'd3; id_reg1_r_ena_i = 1'b1;
        id_reg2_r_addr_i = 5'd5; id_reg2_r_ena_i = 1'b1;
        step(E_LU, "load_use_rs2");
        id_reg2_r_ena_i = 1'b0;
        step(E_NONE, "rs2_not_read");
        ex_reg_w_addr_i = 5'd0; id_reg1_r_addr_i = 5'd0;
        step(E_NONE, "load_x0_no_stall");
        chk_cnt("cnt_after_load_use");

        // Jump, and jump masking a simultaneous load-use
        idle();
        ex_jump_ena_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
        step(e_jump(32'h0000_0100), "jump");
        ex_mem_r_ena_i = 1'b1; ex_reg_w_addr_i = 5'd7;
        id_reg1_r_addr_i = 5'd7; id_reg1_r_ena_i = 1'b1;
        ex_jump_addr_i = 32'h0000_0200;
        step(e_jump(32'h0000_0200), "jump_over_load_use");
        idle();
        ex_jump_addr_i = 32'hDEAD_BEEF;
        step(E_NONE, "no_jump_addr_zero");

        // Divide held 8 cycles: 7 holds then done; a jump during the hold is ignored
        idle();
        ex_div_start_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ex_jump_ena_i  = (i == 2);
            ex_jump_addr_i = 32'h0000_0300;
            step(E_DIV, "div_hold");
        end
        ex_jump_ena_i = 1'b0;
        step(E_DONE, "div_done");
        ex_div_start_i = 1'b0;
        step(E_NONE, "after_div");
        chk_cnt("cnt_after_div");

        // Memory wait: ack in first cycle, then ack after 3 cycles
        idle();
        dmem_req_i = 1'b1; dmem_ack_i = 1'b1;
        step(E_NONE, "mem_ack_immediate");
        dmem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) step(E_MEM, "mem_wait");
        dmem_ack_i = 1'b1;
        step(E_NONE, "mem_ack_release");
        idle();
        step(E_NONE, "after_mem");

        // Memory wait interrupting a divide: 8 non-memory cycles in total
        ex_div_start_i = 1'b1;
        for (int i = 0; i < 3; i++) step(E_DIV, "div_pre_mem");
        dmem_req_i = 1'b1;
        for (int i = 0; i < 2; i++) step(E_MEM, "mem_in_div");
        dmem_ack_i = 1'b1;
        step(E_DIV, "div_resume_on_ack");
        dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) step(E_DIV, "div_post_mem");
        step(E_DONE, "div_done_after_mem");
        idle();
        step(E_NONE, "after_div_mem");
        chk_cnt("cnt_after_div_mem");

        // Timeout: 4 hold cycles, bus error pulse, back in RUN
        dmem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) step(E_MEM, "timeout_hold");
        step(E_ERR, "bus_err");
        idle();
        step(E_NONE, "after_bus_err");
        dmem_req_i = 1'b1;
        step(E_MEM, "new_req_from_run");
        dmem_ack_i = 1'b1;
        step(E_NONE, "new_req_ack");
        idle();

        // Reset in the middle of a divide
        ex_div_start_i = 1'b1;
        step(E_DIV, "div_before_reset");
        step(E_DIV, "div_before_reset");
        arst_n = 1'b0;
        exp_stall = '0;
        step(E_NONE, "reset_mid_div");
        chk_cnt("cnt_cleared_by_reset");
        idle();
        arst_n = 1'b1;
        step(E_NONE, "after_reset_no_done");
        ex_jump_ena_i = 1'b1; ex_jump_addr_i = 32'h0000_0400;
        step(e_jump(32'h0000_0400), "jump_in_run_after_reset");
        idle();

        // Counter saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        exp_stall = 32'hFFFF_FFFD;
        @(negedge clk_100MHz);
        dmem_req_i = 1'b1;
        step(E_MEM, "sat_hold");
        chk_cnt("cnt_near_max");
        for (int i = 0; i < 2; i++) step(E_MEM, "sat_hold");
        chk_cnt("cnt_saturated");
        dmem_ack_i = 1'b1;
        step(E_NONE, "sat_release");
        idle();
        step(E_NONE, "sat_idle");
        chk_cnt("cnt_stays_max");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and flow controller for the 5-stage pipeline. Generates per-stage `hold` and flush (`jump_ena`) controls for the PC, IF/ID, ID/EX and EX/MEM registers from load-use hazards, EX-stage jumps, multi-cycle divide occupancy and data-memory wait handshakes. Maintains a saturating stall-cycle performance counter. Sits beside the pipeline registers and drives their `hold_ena_i`/`jump_ena_i` inputs.

## Interface

- `DIV_CYCLES`, 8: total cycles a divide occupies EX (≥2)
- `MEM_TIMEOUT`, 16: max data-memory wait cycles before forced release (≥1)
- `clk_100MHz` in 1: clock, single domain
- `arst_n` in 1: asynchronous active-low reset
- `id_reg1_r_addr_i` / `id_reg2_r_addr_i` in `REG_ADDR`: source addresses of the ID instruction
- `id_reg1_r_ena_i` / `id_reg2_r_ena_i` in 1: ID instruction actually reads rs1/rs2
- `ex_mem_r_ena_i` in 1: EX instruction is a load
- `ex_reg_w_addr_i` in `REG_ADDR`: EX destination register
- `ex_jump_ena_i` in 1, `ex_jump_addr_i` in `INST_ADDR`: taken jump/branch resolved in EX
- `ex_div_start_i` in 1: EX instruction is a divide
- `dmem_req_i` / `dmem_ack_i` in 1: MEM-stage data-memory request/acknowledge
- `hold_pc_o`, `hold_if_id_o`, `hold_id_ex_o`, `hold_ex_mem_o` out 1: stage holds
- `flush_if_id_o`, `flush_id_ex_o`, `flush_ex_mem_o` out 1: bubble insert (to `jump_ena_i`)
- `pc_jump_ena_o` out 1, `pc_jump_addr_o` out `INST_ADDR`: PC redirect
- `div_done_o` out 1: divide result valid this cycle
- `bus_err_o` out 1: one-cycle pulse on memory timeout
- `stall_cnt_o` out 32: saturating count of cycles with `hold_pc_o`=1

## Operation

- FSM states: RUN, DIV_WAIT, MEM_WAIT. Reset → RUN, counters 0, `stall_cnt_o`=0.
- All outputs except `stall_cnt_o` are combinational from state/counters/inputs; with reset asserted every control output is 0.
- `mem_stall` = `dmem_req_i` & !`dmem_ack_i` & (state≠MEM_WAIT | wait_cnt≠0).
- Priority per cycle: mem_stall > divide > jump > load-use.
- mem_stall: all four holds = 1, no flushes, no redirect. RUN/DIV_WAIT → MEM_WAIT, wait_cnt ← MEM_TIMEOUT-1. In MEM_WAIT, wait_cnt decrements each stalled cycle. On ack, return to RUN, or to DIV_WAIT if a divide was frozen. On wait_cnt==0 without ack, release holds for one cycle, pulse `bus_err_o`, and return.
- Divide: in RUN with `ex_div_start_i`, hold PC, IF/ID and ID/EX, flush EX/MEM, then → DIV_WAIT with div_cnt ← DIV_CYCLES-2. In DIV_WAIT with div_cnt≠0, apply the same holds and flush and decrement. At div_cnt==0, release all holds, `div_done_o`=1, → RUN. The still-high `ex_div_start_i` in the release cycle does not retrigger. div_cnt is frozen during a mem stall.
- Jump: `ex_jump_ena_i` with no higher-priority event sets `pc_jump_ena_o`=1, `pc_jump_addr_o`=`ex_jump_addr_i`, and `flush_if_id_o`=`flush_id_ex_o`=1. A jump is ignored while EX is held, and acts on the cycle the hold releases.
- Load-use hazard: `ex_mem_r_ena_i` & `ex_reg_w_addr_i`≠0 & ((`id_reg1_r_ena_i` & rs1==rd) | (`id_reg2_r_ena_i` & rs2==rd)). Response is `hold_pc_o`=`hold_if_id_o`=1 and `flush_id_ex_o`=1 for exactly one cycle. It is suppressed by a jump in the same cycle, because the ID instruction is squashed.
- `pc_jump_addr_o` = 0 when `pc_jump_ena_o`=0.
- `stall_cnt_o` increments on each clock with `hold_pc_o`=1 and saturates at 0xFFFF_FFFF.

## Timing

- Load-use costs 1 bubble. Jump costs 2 flushed slots.
- A divide occupies EX for exactly DIV_CYCLES cycles, with DIV_CYCLES-1 hold cycles.
- A memory wait holds for every cycle ack is low, up to MEM_TIMEOUT cycles. Ack in the first request cycle gives 0 stall.
- Holds are same-cycle (Mealy), so pipeline registers sample them at the next edge.
- Reset asserted mid-DIV_WAIT or mid-MEM_WAIT → RUN immediately. Counters clear and no `div_done_o` or `bus_err_o` is emitted.

## Structure

- Shared `define.v` gains `HOLD_ENABLE`/`JUMP_ENABLE` (existing) plus FSM state encodings `PCTRL_RUN`, `PCTRL_DIV`, `PCTRL_MEM` (2 bits).
- One sub-module, `hazard_detect`: purely combinational load-use comparator. FSM, counters and priority mux stay in `pipe_ctrl`.

## Test plan

- Load x5, then `add` reading x5 in ID → one cycle with `hold_pc_o`=`hold_if_id_o`=`flush_id_ex_o`=1, then normal flow. With rd=x0 → no stall.
- Jump in EX to 0x0000_0100 → `pc_jump_ena_o`=1, address 0x100, IF/ID and ID/EX flushed, in the same cycle as a load-use condition → load-use suppressed.
- DIV_CYCLES=8, `ex_div_start_i` held 8 cycles → 7 hold cycles, `div_done_o` in cycle 8, `stall_cnt_o` +7.
- `dmem_req_i`=1, ack after 3 cycles → 3 cycles all holds = 1, release on ack. Repeat with a mem stall during a divide → div_cnt frozen, divide still totals 8 non-mem cycles.
- MEM_TIMEOUT=4, ack never → 4 hold cycles, then `bus_err_o` pulse, state RUN.
- `arst_n` low during DIV_WAIT → all outputs 0, state RUN, `stall_cnt_o`=0. Force `stall_cnt_o` near max → saturates at 0xFFFF_FFFF.
